conv2d_sched_fsm: RTL and testbench

Parametrised next-generation control FSM for the conv2d datapath. It accepts one input window per handshake, then sweeps output channels in groups of PAR_OC parallel PEs. For each group it sequences weight fetch (with configurable read latency), PE start, PE pipeline drain, and a valid/ready output handshake. It counts windows per frame and pulses frame_done on the last output pixel.

---
 rtl/conv2d_pkg.sv | 18 +
 rtl/conv2d_lat_counter.sv | 30 +++
 rtl/conv2d_sched_fsm.sv | 153 +++++++++++++++
 tb/tb_conv2d_sched_fsm.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared types for the conv2d scheduler: FSM state encoding and channel-group sizing.
package conv2d_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WIN,
        S_FETCH_W,
        S_WAIT_W,
        S_RUN,
        S_WAIT_PE,
        S_EMIT
    } state_t;

    function automatic int num_groups(input int num_out_channels, input int par_oc);
        return num_out_channels / par_oc;
    endfunction

endpackage

// File: rtl/conv2d_lat_counter.sv
// Loadable down-counter: load presets MAX-1, dec counts toward 0, done_o is high at 0.
// One dec per cycle gives a wait of exactly MAX cycles between load and done.
module conv2d_lat_counter #(
    parameter int MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] LOAD_VAL = (MAX > 0) ? W'(MAX - 1) : '0;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/conv2d_sched_fsm.sv
// conv2d control FSM: one window per accept, sweeps PAR_OC-wide channel groups with weight/PE waits.
// CONV2D_PERF_CNT_EN adds saturating stall and window counters. Outputs decode from state only.
module conv2d_sched_fsm
    import conv2d_pkg::*;
#(
    parameter int NUM_OUT_CHANNELS = 8,
    parameter int PAR_OC           = 2,
    parameter int WADDR_W          = 8,
    parameter int WEIGHT_RD_LAT    = 1,
    parameter int PE_LAT           = 3,
    parameter int OUT_H            = 8,
    parameter int OUT_W            = 8,
    localparam int NUM_GROUPS      = num_groups(NUM_OUT_CHANNELS, PAR_OC),
    localparam int GRP_W           = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               lb_en,
    output logic               weight_rd_en,
    output logic [WADDR_W-1:0] weight_rd_addr,
    output logic               pe_start,
    output logic               activation_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GRP_W-1:0]   oc_group,
    output logic               last_group,
    output logic               frame_done,
`ifdef CONV2D_PERF_CNT_EN
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_windows,
`endif
    output logic               busy
);

    localparam int NPIX  = OUT_H * OUT_W;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    if ((NUM_OUT_CHANNELS % PAR_OC) != 0) begin : g_bad_par_oc
        $error("conv2d_sched_fsm: PAR_OC must divide NUM_OUT_CHANNELS");
    end
    if (NUM_GROUPS > (2 ** WADDR_W)) begin : g_bad_waddr_w
        $error("conv2d_sched_fsm: NUM_GROUPS exceeds weight address space");
    end

    state_t           state_q, state_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             frame_done_q, frame_done_d;
    logic             last_grp;
    logic             w_done, pe_done;

    assign last_grp = (grp_q == GRP_W'(NUM_GROUPS - 1));

    conv2d_lat_counter #(.MAX(WEIGHT_RD_LAT)) u_wait_w (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == S_FETCH_W),
        .dec_i  (state_q == S_WAIT_W),
        .done_o (w_done)
    );

    conv2d_lat_counter #(.MAX(PE_LAT)) u_wait_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == S_RUN),
        .dec_i  (state_q == S_WAIT_PE),
        .done_o (pe_done)
    );

    always_comb begin
        state_d      = state_q;
        grp_d        = grp_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_LOAD_WIN;
                    grp_d   = '0;
                end
            end
            S_LOAD_WIN: state_d = S_FETCH_W;
            S_FETCH_W:  state_d = (WEIGHT_RD_LAT == 0) ? S_RUN : S_WAIT_W;
            S_WAIT_W:   if (w_done) state_d = S_RUN;
            S_RUN:      state_d = (PE_LAT == 0) ? S_EMIT : S_WAIT_PE;
            S_WAIT_PE:  if (pe_done) state_d = S_EMIT;
            S_EMIT: begin
                if (out_ready) begin
                    if (last_grp) begin
                        state_d = S_IDLE;
                        // Last pixel of the frame wraps the counter and flags frame_done next cycle.
                        if (pix_q == PIX_W'(NPIX - 1)) begin
                            pix_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end else begin
                        grp_d   = grp_q + 1'b1;
                        state_d = S_FETCH_W;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grp_q        <= '0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grp_q        <= grp_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign lb_en          = (state_q == S_LOAD_WIN);
    assign weight_rd_en   = (state_q == S_FETCH_W);
    assign weight_rd_addr = WADDR_W'(grp_q);
    assign pe_start       = (state_q == S_RUN);
    assign activation_en  = (state_q == S_EMIT);
    assign out_valid      = (state_q == S_EMIT);
    assign oc_group       = grp_q;
    assign last_group     = last_grp;
    assign frame_done     = frame_done_q;
    assign busy           = (state_q != S_IDLE);

`ifdef CONV2D_PERF_CNT_EN
    logic [31:0] stall_q, win_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            win_q   <= '0;
        end else begin
            if ((state_q == S_EMIT) && !out_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if ((state_q == S_IDLE) && in_valid && (win_q != '1))     win_q   <= win_q + 1'b1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_windows      = win_q;
`endif

endmodule

// File: tb/tb_conv2d_sched_fsm.sv
// Directed bench: main instance (defaults, 2x2 frame) and a zero-latency single-group corner instance.
module tb_conv2d_sched_fsm;

    logic clk;
    logic rst_n;

    logic       m_in_valid, m_in_ready, m_lb_en, m_wr_en, m_pe_start, m_act_en;
    logic       m_out_valid, m_out_ready, m_last_group, m_frame_done, m_busy;
    logic [7:0] m_wr_addr;
    logic [1:0] m_oc_group;

    logic       c_in_valid, c_in_ready, c_lb_en, c_wr_en, c_pe_start, c_act_en;
    logic       c_out_valid, c_out_ready, c_last_group, c_frame_done, c_busy;
    logic [7:0] c_wr_addr;
    logic [0:0] c_oc_group;

`ifdef CONV2D_PERF_CNT_EN
    logic [31:0] m_perf_stall, m_perf_win, c_perf_stall, c_perf_win;
`endif

    int total = 0;
    int bad   = 0;

    conv2d_sched_fsm #(
        .NUM_OUT_CHANNELS(8), .PAR_OC(2), .WADDR_W(8),
        .WEIGHT_RD_LAT(1), .PE_LAT(3), .OUT_H(2), .OUT_W(2)
    ) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .lb_en(m_lb_en),
        .weight_rd_en(m_wr_en), .weight_rd_addr(m_wr_addr), .pe_start(m_pe_start),
        .activation_en(m_act_en), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .oc_group(m_oc_group), .last_group(m_last_group), .frame_done(m_frame_done),
`ifdef CONV2D_PERF_CNT_EN
        .perf_stall_cycles(m_perf_stall), .perf_windows(m_perf_win),
`endif
        .busy(m_busy)
    );

    conv2d_sched_fsm #(
        .NUM_OUT_CHANNELS(4), .PAR_OC(4), .WADDR_W(8),
        .WEIGHT_RD_LAT(0), .PE_LAT(0), .OUT_H(8), .OUT_W(8)
    ) u_corner (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .lb_en(c_lb_en),
        .weight_rd_en(c_wr_en), .weight_rd_addr(c_wr_addr), .pe_start(c_pe_start),
        .activation_en(c_act_en), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .oc_group(c_oc_group), .last_group(c_last_group), .frame_done(c_frame_done),
`ifdef CONV2D_PERF_CNT_EN
        .perf_stall_cycles(c_perf_stall), .perf_windows(c_perf_win),
`endif
        .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if ({m_in_ready, m_busy, m_lb_en, m_wr_en, m_pe_start, m_act_en, m_out_valid, m_frame_done} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 10000000",
                     {m_in_ready, m_busy, m_lb_en, m_wr_en, m_pe_start, m_act_en, m_out_valid, m_frame_done});
        end
        total++;
        if ({m_oc_group, m_last_group, m_wr_addr} !== 11'd0) begin
            bad++;
            $display("FAIL reset_group: oc_group=%0d last=%0d addr=%0d want 0 0 0", m_oc_group, m_last_group, m_wr_addr);
        end
        total++;
        if ({c_in_ready, c_last_group, c_busy} !== 3'b110) begin
            bad++;
            $display("FAIL reset_corner: in_ready/last/busy=%b want 110", {c_in_ready, c_last_group, c_busy});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_window();
        int ov_k[$];
        int wr_k[$];
        int wr_a[$];
        int pe_n = 0;
        int lb_n = 0;
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        tick();
        m_in_valid  = 1'b0;
        total++;
        if ({m_in_ready, m_lb_en} !== 2'b01) begin
            bad++;
            $display("FAIL accept: in_ready/lb_en=%b want 01", {m_in_ready, m_lb_en});
        end
        for (int k = 0; k <= 29; k++) begin
            if (k > 0) tick();
            if (m_out_valid) ov_k.push_back(k);
            if (m_wr_en) begin
                wr_k.push_back(k);
                wr_a.push_back(int'(m_wr_addr));
            end
            if (m_pe_start) pe_n++;
            if (m_lb_en) lb_n++;
        end
        total++;
        if (ov_k.size() != 4 || wr_k.size() != 4) begin
            bad++;
            $display("FAIL sweep_counts: out_valid=%0d rd_en=%0d want 4 4", ov_k.size(), wr_k.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (ov_k[i] != 7 + 7 * i || wr_k[i] != 1 + 7 * i || wr_a[i] != i) begin
                    bad++;
                    $display("FAIL sweep_group%0d: valid_at=%0d rd_at=%0d addr=%0d want %0d %0d %0d",
                             i, ov_k[i], wr_k[i], wr_a[i], 7 + 7 * i, 1 + 7 * i, i);
                end
            end
        end
        total++;
        if (pe_n != 4 || lb_n != 1) begin
            bad++;
            $display("FAIL sweep_pulses: pe_start=%0d lb_en=%0d want 4 1", pe_n, lb_n);
        end
        total++;
        if ({m_busy, m_in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL sweep_idle: busy/in_ready=%b want 01", {m_busy, m_in_ready});
        end
    endtask

    task automatic test_backpressure();
        int pe_n = 0;
        do_reset();
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        tick();
        m_in_valid  = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            if (k > 0) tick();
            if (m_pe_start) pe_n++;
            if (k >= 14 && k <= 19) begin
                total++;
                if ({m_out_valid, m_oc_group} !== 3'b101) begin
                    bad++;
                    $display("FAIL stall_hold k=%0d: out_valid/oc_group=%b want 101", k, {m_out_valid, m_oc_group});
                end
            end
            if (k == 10) m_out_ready = 1'b0;
            if (k == 19) m_out_ready = 1'b1;
        end
        total++;
        if (pe_n != 4 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_done: pe_start=%0d busy=%b want 4 0", pe_n, m_busy);
        end
`ifdef CONV2D_PERF_CNT_EN
        total++;
        if (m_perf_stall !== 32'd5 || m_perf_win !== 32'd1) begin
            bad++;
            $display("FAIL perf: stall=%0d windows=%0d want 5 1", m_perf_stall, m_perf_win);
        end
`endif
    endtask

    task automatic test_latency_corner();
        int ov_k[$];
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        tick();
        c_in_valid  = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            if (c_out_valid) ov_k.push_back(k);
            total++;
            if (c_last_group !== 1'b1) begin
                bad++;
                $display("FAIL corner_last k=%0d: got %b want 1", k, c_last_group);
            end
            if (k == 4) begin
                total++;
                if (c_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL corner_idle: busy=%b want 0", c_busy);
                end
            end
        end
        total++;
        if (ov_k.size() != 1 || ov_k[0] != 3) begin
            bad++;
            $display("FAIL corner_latency: pulses=%0d first=%0d want 1 at 3",
                     ov_k.size(), (ov_k.size() > 0) ? ov_k[0] : -1);
        end
    endtask

    task automatic test_frame_wrap();
        int acc_k[$];
        int fd_k[$];
        do_reset();
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        tick();
        for (int k = 0; k <= 149; k++) begin
            if (k > 0) tick();
            if (m_lb_en) acc_k.push_back(k);
            if (m_frame_done) fd_k.push_back(k);
            if (k == 119) begin
                total++;
                if (m_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap_idle: busy=%b want 0 with frame_done", m_busy);
                end
            end
            if (k == 149) m_in_valid = 1'b0;
        end
        total++;
        if (acc_k.size() != 5) begin
            bad++;
            $display("FAIL held_valid_accepts: got %0d want 5", acc_k.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (acc_k[i] != 30 * i) begin
                    bad++;
                    $display("FAIL accept_spacing%0d: got %0d want %0d", i, acc_k[i], 30 * i);
                end
            end
        end
        total++;
        if (fd_k.size() != 1 || fd_k[0] != 119) begin
            bad++;
            $display("FAIL frame_done: pulses=%0d first=%0d want 1 at 119",
                     fd_k.size(), (fd_k.size() > 0) ? fd_k[0] : -1);
        end
    endtask

    task automatic test_reset_mid_run();
        int fd_k[$];
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        tick();
        m_in_valid  = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_in_ready, m_busy, m_pe_start, m_wr_en, m_out_valid, m_lb_en} !== 6'b100000 || m_oc_group !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: ctrl=%b oc_group=%0d want 100000 0",
                     {m_in_ready, m_busy, m_pe_start, m_wr_en, m_out_valid, m_lb_en}, m_oc_group);
        end
        #1;
        rst_n = 1'b1;
        tick();
        m_in_valid = 1'b1;
        tick();
        total++;
        if ({m_lb_en, m_oc_group} !== 3'b100) begin
            bad++;
            $display("FAIL restart: lb_en/oc_group=%b want 100", {m_lb_en, m_oc_group});
        end
        for (int k = 0; k <= 119; k++) begin
            if (k > 0) tick();
            if (m_frame_done) fd_k.push_back(k);
            if (k == 119) m_in_valid = 1'b0;
        end
        total++;
        if (fd_k.size() != 1 || fd_k[0] != 119) begin
            bad++;
            $display("FAIL pixel_cleared: pulses=%0d first=%0d want 1 at 119",
                     fd_k.size(), (fd_k.size() > 0) ? fd_k[0] : -1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        m_in_valid  = 1'b0;
        m_out_ready = 1'b0;
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        test_reset();
        test_single_window();
        test_backpressure();
        test_latency_corner();
        test_frame_wrap();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
